// File: rtl/microcode_sequencer_if.sv
// Purpose: bundles the sequencer's datapath-facing signals so that the
//          sequencer and its environment connect through one port.
// Ports / signals:
//   stall    - 1 freezes the sequencer for the current cycle
//   zf, cf   - ALU zero / carry flags used by conditional microwords
//   ireg     - current opcode, stable from step 2 until instruction end
//   uc_we    - microcode RAM write strobe
//   uc_addr  - microcode write address {opcode, substep}
//   uc_wdata - microcode write data {cond[1:0], end, ctrl}
//   ctrl     - registered control word driven to the datapath
//   step     - current step (0,1 fetch; 2.. execute)
//   in_fetch - 1 while step is 0 or 1
// Modports: master drives the inputs (control environment / bench),
//           slave is the sequencer itself.
interface microcode_sequencer_if #(
    parameter int CTRL_W    = 16,
    parameter int OPC_W     = 8,
    parameter int MAX_STEPS = 8
);
    localparam int SW     = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;
    localparam int STEP_W = $clog2(MAX_STEPS + 2);

    logic                  stall;
    logic                  zf;
    logic                  cf;
    logic [OPC_W-1:0]      ireg;
    logic                  uc_we;
    logic [OPC_W+SW-1:0]   uc_addr;
    logic [CTRL_W+2:0]     uc_wdata;
    logic [CTRL_W-1:0]     ctrl;
    logic [STEP_W-1:0]     step;
    logic                  in_fetch;

    modport master (
        output stall, zf, cf, ireg, uc_we, uc_addr, uc_wdata,
        input  ctrl, step, in_fetch
    );

    modport slave (
        input  stall, zf, cf, ireg, uc_we, uc_addr, uc_wdata,
        output ctrl, step, in_fetch
    );
endinterface

// File: rtl/microcode_sequencer.sv
// Purpose: microcoded CPU control sequencer. Every instruction starts with a
//          fixed two-step fetch (FETCH0, FETCH1), then walks up to MAX_STEPS
//          microwords read from a writable RAM indexed by {ireg, substep}.
//          Each microword carries a control word, an end bit and a flag
//          condition that can abort the instruction early.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset (ctrl=0, step=0; RAM untouched)
//   bus  - microcode_sequencer_if slave modport (flags, opcode, stall,
//          microcode write port, ctrl/step/in_fetch outputs)
module microcode_sequencer #(
    parameter int                 CTRL_W    = 16,
    parameter int                 OPC_W     = 8,
    parameter int                 MAX_STEPS = 8,
    parameter logic [CTRL_W-1:0]  FETCH0    = '0,
    parameter logic [CTRL_W-1:0]  FETCH1    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    microcode_sequencer_if.slave   bus
);
    // A single-step configuration would give a zero-width substep field.
    localparam int SW     = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;
    localparam int STEP_W = $clog2(MAX_STEPS + 2);

    typedef enum logic [1:0] {
        COND_NONE = 2'b00,
        COND_ZF   = 2'b01,
        COND_CF   = 2'b10,
        COND_NZ   = 2'b11
    } cond_e;

    logic [CTRL_W+2:0]   ram [2**(OPC_W+SW)];

    logic [CTRL_W-1:0]   ctrl_q;
    logic [STEP_W-1:0]   step_q;
    logic [CTRL_W-1:0]   ctrl_d;
    logic [STEP_W-1:0]   step_d;

    logic [STEP_W-1:0]   sub_full;
    logic [SW-1:0]       substep;
    logic [CTRL_W+2:0]   word;
    cond_e               word_cond;
    logic                word_end;
    logic                cond_ok;

    // Microcode RAM write port. No reset so software-loaded microcode
    // survives a sequencer reset.
    always_ff @(posedge clk) begin
        if (bus.uc_we) begin
            ram[bus.uc_addr] <= bus.uc_wdata;
        end
    end

    // Asynchronous read: a write landing on the same edge is not yet
    // visible, so a simultaneous read of that address sees the old word.
    assign sub_full  = step_q - STEP_W'(2);
    assign substep   = sub_full[SW-1:0];
    assign word      = ram[{bus.ireg, substep}];
    assign word_cond = cond_e'(word[CTRL_W+2:CTRL_W+1]);
    assign word_end  = word[CTRL_W];

    // Flags are used live on the edge that latches the microword.
    always_comb begin
        cond_ok = 1'b1;
        case (word_cond)
            COND_NONE: cond_ok = 1'b1;
            COND_ZF:   cond_ok = bus.zf;
            COND_CF:   cond_ok = bus.cf;
            COND_NZ:   cond_ok = ~bus.zf;
            default:   cond_ok = 1'b1;
        endcase
    end

    // State register: step counter plus the registered control word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q <= '0;
            ctrl_q <= '0;
        end else begin
            step_q <= step_d;
            ctrl_q <= ctrl_d;
        end
    end

    // Next-state logic. The microword's ctrl is issued even when its
    // condition fails or it ends the instruction.
    always_comb begin
        step_d = step_q;
        ctrl_d = ctrl_q;
        if (!bus.stall) begin
            if (step_q == STEP_W'(0)) begin
                ctrl_d = FETCH0;
                step_d = STEP_W'(1);
            end else if (step_q == STEP_W'(1)) begin
                ctrl_d = FETCH1;
                step_d = STEP_W'(2);
            end else begin
                ctrl_d = word[CTRL_W-1:0];
                if (!cond_ok || word_end || sub_full == STEP_W'(MAX_STEPS - 1)) begin
                    step_d = '0;
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
        end
    end

    // Outputs come straight from the state register.
    always_comb begin
        bus.ctrl     = ctrl_q;
        bus.step     = step_q;
        bus.in_fetch = (step_q < STEP_W'(2));
    end
endmodule

// File: tb/tb_microcode_sequencer.sv
// Purpose: self-checking bench for microcode_sequencer (MAX_STEPS=4).
//          Expected ctrl/step values are pushed to a scoreboard queue as each
//          cycle's stimulus is driven and popped/compared after the edge.
module tb_microcode_sequencer;
    localparam int          CTRL_W    = 16;
    localparam int          OPC_W     = 8;
    localparam int          MAX_STEPS = 4;
    localparam logic [15:0] F0        = 16'hA001;
    localparam logic [15:0] F1        = 16'h5002;

    typedef struct {
        string       tag;
        logic [15:0] ctrl;
        logic [2:0]  step;
    } exp_t;

    logic clk;
    logic rst;
    int   checkCount;
    int   passCount;
    exp_t sb[$];

    microcode_sequencer_if #(.CTRL_W(CTRL_W), .OPC_W(OPC_W), .MAX_STEPS(MAX_STEPS)) bus ();

    microcode_sequencer #(
        .CTRL_W(CTRL_W), .OPC_W(OPC_W), .MAX_STEPS(MAX_STEPS),
        .FETCH0(F0), .FETCH1(F1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts and reports.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h required %0h", tag, actual, expected);
        end
    endtask

    // Preload one microword (one clock).
    task automatic writeWord(input logic [7:0] op, input logic [1:0] sub, input logic [1:0] cond,
                             input logic e, input logic [15:0] w);
        bus.uc_we    = 1'b1;
        bus.uc_addr  = {op, sub};
        bus.uc_wdata = {cond, e, w};
        @(posedge clk);
        #1;
        bus.uc_we    = 1'b0;
    endtask

    // Arm a write that will coincide with the next applyStimulus edge.
    task automatic armWrite(input logic [7:0] op, input logic [1:0] sub, input logic [1:0] cond,
                            input logic e, input logic [15:0] w);
        bus.uc_we    = 1'b1;
        bus.uc_addr  = {op, sub};
        bus.uc_wdata = {cond, e, w};
    endtask

    // Drive one cycle, record what the sequencer must show after the edge,
    // then pop and compare.
    task automatic applyStimulus(input string tag, input logic st, input logic z, input logic c,
                                 input logic [7:0] op, input logic [15:0] eCtrl, input logic [2:0] eStep);
        exp_t e;
        bus.stall = st;
        bus.zf    = z;
        bus.cf    = c;
        bus.ireg  = op;
        e.tag  = tag;
        e.ctrl = eCtrl;
        e.step = eStep;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.uc_we = 1'b0;
        e = sb.pop_front();
        checkOutput({e.tag, ".ctrl"}, 32'(bus.ctrl), 32'(e.ctrl));
        checkOutput({e.tag, ".step"}, 32'(bus.step), 32'(e.step));
        checkOutput({e.tag, ".in_fetch"}, 32'(bus.in_fetch), 32'(e.step < 3'd2));
    endtask

    // Two fetch cycles starting from step 0.
    task automatic fetch(input string tag, input logic [7:0] op);
        applyStimulus({tag, ".f0"}, 1'b0, 1'b0, 1'b0, op, F0, 3'd1);
        applyStimulus({tag, ".f1"}, 1'b0, 1'b0, 1'b0, op, F1, 3'd2);
    endtask

    initial begin
        checkCount   = 0;
        passCount    = 0;
        rst          = 1'b1;
        bus.stall    = 1'b0;
        bus.zf       = 1'b0;
        bus.cf       = 1'b0;
        bus.ireg     = '0;
        bus.uc_we    = 1'b0;
        bus.uc_addr  = '0;
        bus.uc_wdata = '0;

        // Preload microcode while reset holds the sequencer at step 0.
        writeWord(8'h01, 2'd0, 2'b00, 1'b0, 16'h1111);
        writeWord(8'h01, 2'd1, 2'b00, 1'b0, 16'h2222);
        writeWord(8'h01, 2'd2, 2'b00, 1'b1, 16'h3333);
        writeWord(8'h02, 2'd0, 2'b01, 1'b0, 16'h0000);
        writeWord(8'h02, 2'd1, 2'b00, 1'b1, 16'h4444);
        writeWord(8'h03, 2'd0, 2'b00, 1'b0, 16'h5550);
        writeWord(8'h03, 2'd1, 2'b00, 1'b0, 16'h5551);
        writeWord(8'h03, 2'd2, 2'b00, 1'b0, 16'h5552);
        writeWord(8'h03, 2'd3, 2'b00, 1'b0, 16'h5553);
        writeWord(8'h04, 2'd0, 2'b11, 1'b0, 16'h0008);
        writeWord(8'h04, 2'd1, 2'b00, 1'b1, 16'h9999);
        writeWord(8'h05, 2'd0, 2'b10, 1'b0, 16'h0006);
        writeWord(8'h05, 2'd1, 2'b00, 1'b1, 16'h7777);
        writeWord(8'h06, 2'd0, 2'b00, 1'b1, 16'h0000);

        checkOutput("reset.ctrl", 32'(bus.ctrl), 32'h0);
        checkOutput("reset.step", 32'(bus.step), 32'h0);
        checkOutput("reset.in_fetch", 32'(bus.in_fetch), 32'h1);
        rst = 1'b0;

        // Three-word instruction ending on its last word.
        fetch("op01", 8'h01);
        applyStimulus("op01.w0", 1'b0, 1'b0, 1'b0, 8'h01, 16'h1111, 3'd3);
        applyStimulus("op01.w1", 1'b0, 1'b0, 1'b0, 8'h01, 16'h2222, 3'd4);
        applyStimulus("op01.w2", 1'b0, 1'b0, 1'b0, 8'h01, 16'h3333, 3'd0);

        // NOP: single zero cycle then back to fetch.
        fetch("nop", 8'h06);
        applyStimulus("nop.w0", 1'b0, 1'b0, 1'b0, 8'h06, 16'h0000, 3'd0);

        // Jump-if-zero, taken and not taken.
        fetch("jz0", 8'h02);
        applyStimulus("jz0.w0", 1'b0, 1'b0, 1'b0, 8'h02, 16'h0000, 3'd0);
        fetch("jz1", 8'h02);
        applyStimulus("jz1.w0", 1'b0, 1'b1, 1'b0, 8'h02, 16'h0000, 3'd3);
        applyStimulus("jz1.w1", 1'b0, 1'b0, 1'b0, 8'h02, 16'h4444, 3'd0);

        // Carry condition.
        fetch("jc0", 8'h05);
        applyStimulus("jc0.w0", 1'b0, 1'b1, 1'b0, 8'h05, 16'h0006, 3'd0);
        fetch("jc1", 8'h05);
        applyStimulus("jc1.w0", 1'b0, 1'b0, 1'b1, 8'h05, 16'h0006, 3'd3);
        applyStimulus("jc1.w1", 1'b0, 1'b0, 1'b0, 8'h05, 16'h7777, 3'd0);

        // Not-zero condition.
        fetch("jnz1", 8'h04);
        applyStimulus("jnz1.w0", 1'b0, 1'b1, 1'b0, 8'h04, 16'h0008, 3'd0);
        fetch("jnz0", 8'h04);
        applyStimulus("jnz0.w0", 1'b0, 1'b0, 1'b0, 8'h04, 16'h0008, 3'd3);
        applyStimulus("jnz0.w1", 1'b0, 1'b0, 1'b0, 8'h04, 16'h9999, 3'd0);

        // No end bits: forced end after MAX_STEPS words, with a 3-cycle stall at step 3.
        fetch("max", 8'h03);
        applyStimulus("max.w0", 1'b0, 1'b0, 1'b0, 8'h03, 16'h5550, 3'd3);
        for (int i = 0; i < 3; i++) begin
            applyStimulus("max.stall", 1'b1, 1'b0, 1'b0, 8'h03, 16'h5550, 3'd3);
        end
        applyStimulus("max.w1", 1'b0, 1'b0, 1'b0, 8'h03, 16'h5551, 3'd4);
        applyStimulus("max.w2", 1'b0, 1'b0, 1'b0, 8'h03, 16'h5552, 3'd5);
        applyStimulus("max.w3", 1'b0, 1'b0, 1'b0, 8'h03, 16'h5553, 3'd0);

        // Write to the word being read on the same edge: old data is used.
        fetch("rdw", 8'h01);
        armWrite(8'h01, 2'd0, 2'b00, 1'b0, 16'hABCD);
        applyStimulus("rdw.w0", 1'b0, 1'b0, 1'b0, 8'h01, 16'h1111, 3'd3);
        applyStimulus("rdw.w1", 1'b0, 1'b0, 1'b0, 8'h01, 16'h2222, 3'd4);

        // Asynchronous reset between edges while at step 4.
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst.ctrl", 32'(bus.ctrl), 32'h0);
        checkOutput("midrst.step", 32'(bus.step), 32'h0);
        checkOutput("midrst.in_fetch", 32'(bus.in_fetch), 32'h1);
        #1;
        rst = 1'b0;

        // Restart from fetch; the rewritten word is now visible.
        fetch("new", 8'h01);
        applyStimulus("new.w0", 1'b0, 1'b0, 1'b0, 8'h01, 16'hABCD, 3'd3);
        applyStimulus("new.w1", 1'b0, 1'b0, 1'b0, 8'h01, 16'h2222, 3'd4);
        applyStimulus("new.w2", 1'b0, 1'b0, 1'b0, 8'h01, 16'h3333, 3'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
